ins_mem_loader: RTL and testbench
=================================

Name: ins_mem_loader

Overview:
- Host-side writer that fills the multicycle CPU's instruction memory before execution. It is the producing end of the CPU's instruction-fetch path.
- Holds the CPU in clear (CPU_Hold drives the CPU CLR input) while it accepts a stream of 32-bit instruction words over a valid/ready handshake. Each word is written to consecutive word addresses.
- When loading completes, it releases the CPU with a defined start PC.

Parameters:
- ADDR_W, 8, word-address width of instruction memory.
- DEPTH, 256, number of instruction words; must equal 2**ADDR_W.
- START_PC, 32'h0000_0000, byte PC driven on PC_Value at release.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- Load_Start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- Load_Len  in  ADDR_W+1  word count for this load, sampled with Load_Start; legal range 1..DEPTH.
- In_Valid  in  1  host word valid.
- In_Data  in  32  host instruction word.
- In_Ready  out  1  loader accepts a word this cycle.
- Mem_WE  out  1  instruction-memory write enable.
- Mem_Addr  out  ADDR_W  instruction-memory word address.
- Mem_WData  out  32  instruction-memory write data.
- CPU_Hold  out  1  holds the CPU in clear (to CPU CLR).
- PC_Value  out  32  start PC presented to the CPU.
- Busy  out  1  load in progress.
- Done  out  1  one-cycle pulse when the CPU is released.
- Err  out  1  sticky illegal-length flag.
- Checksum  out  32  XOR of all words accepted in the current or last load.

Behaviour:
- Reset values (synchronous RST=1):
  - State=IDLE.
  - CPU_Hold=1, so the CPU is held after power-up until the first load.
  - In_Ready=0, Mem_WE=0, Mem_Addr=0, Mem_WData=0.
  - PC_Value=START_PC, Busy=0, Done=0, Err=0, Checksum=0.
- State IDLE:
  - In_Ready=0.
  - Load_Start=1 with 1<=Load_Len<=DEPTH:
    - latch Load_Len into the remaining counter;
    - clear the word counter and Checksum; clear Err;
    - set CPU_Hold=1 and Busy=1;
    - go to LOAD.
  - Load_Start=1 with Load_Len=0 or Load_Len>DEPTH:
    - set Err=1;
    - stay in IDLE; CPU_Hold and Checksum unchanged.
- State LOAD:
  - In_Ready=1 combinationally in this state, with no dependency on In_Valid.
  - A transfer occurs on a cycle with In_Valid&&In_Ready. On the next cycle:
    - Mem_WE=1, Mem_Addr=word counter, Mem_WData=In_Data;
    - word counter increments; Checksum^=In_Data.
  - Write latency is exactly 1 cycle after the handshake.
  - Mem_WE=0 on every cycle not following a transfer.
  - Back-to-back transfers are sustained at 1 word/cycle.
  - When the transfer of word number Load_Len occurs, go to DRAIN.
- State DRAIN:
  - In_Ready=0.
  - The final write is performed this cycle (Mem_WE=1).
  - Go to RELEASE.
- State RELEASE (one cycle):
  - CPU_Hold falls to 0 at the end of this cycle.
  - Done=1 for exactly this cycle.
  - PC_Value=START_PC.
  - Busy falls to 0.
  - Go to IDLE.
- Hold ordering: CPU_Hold is never 0 while any write to instruction memory is pending.
- Address wrap: with Load_Len=DEPTH, the last write lands at address DEPTH-1. The word counter never wraps within a load.
- Load_Start outside IDLE is ignored and does not set Err.
- In_Valid in IDLE, DRAIN or RELEASE is ignored; no write occurs and Checksum is unchanged.
- Mid-load reset: RST=1 in any state forces the reset values on the next edge. CPU_Hold stays 1 and any partial load is abandoned; no Done is produced.
- Simultaneous RST and Load_Start: RST wins.
- After release, CPU_Hold stays 0 until the next legal Load_Start or RST.

Test Plan:
- Basic load:
  - Stimulus: RST 2 cycles, then Load_Start with Load_Len=3; words 32'h2001_0005, 32'h2002_0007, 32'h0022_1820 back-to-back.
  - Required: writes at addresses 0,1,2, each one cycle after its handshake.
  - Required: Checksum=XOR of the three words; Done pulses once; CPU_Hold falls in that same cycle; PC_Value=0.
- Gapped valid:
  - Stimulus: Load_Len=2, In_Valid deasserted for 4 cycles between the words.
  - Required: exactly 2 Mem_WE pulses, at addresses 0 and 1; no write during the gap; Busy=1 throughout.
- Full depth:
  - Stimulus: Load_Len=256, data=address index.
  - Required: final write at address 255 with data 255; Mem_Addr never returns to 0; Done after the DRAIN cycle.
- Illegal length:
  - Stimulus: Load_Start with Load_Len=0, then Load_Len=257.
  - Required: Err=1, state remains IDLE, no writes, CPU_Hold unchanged.
  - Stimulus: a following legal load.
  - Required: Err clears to 0.
- Reset mid-load:
  - Stimulus: after 5 of 10 words, assert RST for 1 cycle.
  - Required: next cycle Busy=0, CPU_Hold=1, Checksum=0, no Done.
  - Stimulus: a new load of 2 words.
  - Required: the new load starts at address 0.
- Ignored start:
  - Stimulus: Load_Start pulsed during LOAD with a different Load_Len.
  - Required: the original length governs completion; Err stays 0.

Source files
------------

// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: holds the CPU in clear, streams host words into
// consecutive word addresses, then releases the CPU at a fixed start PC.
module ins_mem_loader #(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 256,
    parameter logic [31:0] START_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Load_Start,
    input  logic [ADDR_W:0]   Load_Len,
    input  logic              In_Valid,
    input  logic [31:0]       In_Data,
    output logic              In_Ready,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_WData,
    output logic              CPU_Hold,
    output logic [31:0]       PC_Value,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [31:0]       Checksum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W + 1){1'b0}};

    function automatic logic [31:0] fold_checksum(input logic [31:0] sum, input logic [31:0] word);
        return sum ^ word;
    endfunction

    state_t              r_state;
    logic [ADDR_W:0]     r_remain;
    logic [ADDR_W:0]     r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_sum;
    logic                r_hold;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [31:0]         r_pc;

    state_t              w_state_nx;
    logic [ADDR_W:0]     w_remain_nx;
    logic [ADDR_W:0]     w_cnt_nx;
    logic                w_we_nx;
    logic [ADDR_W-1:0]   w_addr_nx;
    logic [31:0]         w_wdata_nx;
    logic [31:0]         w_sum_nx;
    logic                w_hold_nx;
    logic                w_busy_nx;
    logic                w_done_nx;
    logic                w_err_nx;
    logic [31:0]         w_pc_nx;
    logic                w_len_ok;

    assign w_len_ok = (Load_Len != LEN_ZERO) && (Load_Len <= LEN_MAX);

    // Ready is a pure function of state so the host never sees a valid->ready loop.
    assign In_Ready = (r_state == S_LOAD);

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        w_state_nx  = r_state;
        w_remain_nx = r_remain;
        w_cnt_nx    = r_cnt;
        w_we_nx     = 1'b0;
        w_addr_nx   = r_addr;
        w_wdata_nx  = r_wdata;
        w_sum_nx    = r_sum;
        w_hold_nx   = r_hold;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        w_err_nx    = r_err;
        w_pc_nx     = r_pc;
        case (r_state)
            S_IDLE: begin
                if (Load_Start && w_len_ok) begin
                    w_remain_nx = Load_Len;
                    w_cnt_nx    = LEN_ZERO;
                    w_sum_nx    = 32'h0000_0000;
                    w_err_nx    = 1'b0;
                    w_hold_nx   = 1'b1;
                    w_busy_nx   = 1'b1;
                    w_state_nx  = S_LOAD;
                end else if (Load_Start) begin
                    w_err_nx    = 1'b1;
                end else begin
                    w_state_nx  = S_IDLE;
                end
            end
            S_LOAD: begin
                if (In_Valid) begin
                    w_we_nx     = 1'b1;
                    w_addr_nx   = r_cnt[ADDR_W-1:0];
                    w_wdata_nx  = In_Data;
                    w_cnt_nx    = r_cnt + LEN_ONE;
                    w_remain_nx = r_remain - LEN_ONE;
                    w_sum_nx    = fold_checksum(r_sum, In_Data);
                    if (r_remain == LEN_ONE) begin
                        w_state_nx = S_DRAIN;
                    end else begin
                        w_state_nx = S_LOAD;
                    end
                end else begin
                    w_state_nx = S_LOAD;
                end
            end
            S_DRAIN: begin
                // The last word's write is on the bus now; Done appears next cycle.
                w_done_nx  = 1'b1;
                w_state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                w_hold_nx  = 1'b0;
                w_busy_nx  = 1'b0;
                w_pc_nx    = START_PC;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_remain <= LEN_ZERO;
            r_cnt    <= LEN_ZERO;
            r_we     <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_wdata  <= 32'h0000_0000;
            r_sum    <= 32'h0000_0000;
            r_hold   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_pc     <= START_PC;
        end else begin
            r_state  <= w_state_nx;
            r_remain <= w_remain_nx;
            r_cnt    <= w_cnt_nx;
            r_we     <= w_we_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_sum    <= w_sum_nx;
            r_hold   <= w_hold_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_err    <= w_err_nx;
            r_pc     <= w_pc_nx;
        end
    end

    assign Mem_WE    = r_we;
    assign Mem_Addr  = r_addr;
    assign Mem_WData = r_wdata;
    assign CPU_Hold  = r_hold;
    assign PC_Value  = r_pc;
    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Err       = r_err;
    assign Checksum  = r_sum;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: directed scenarios with random data
// and gaps, compared against an address/data/checksum reference model.
module tb_ins_mem_loader;

    localparam int          ADDR_W   = 8;
    localparam int          DEPTH    = 256;
    localparam logic [31:0] START_PC = 32'h0000_0000;

    logic              CLK;
    logic              RST;
    logic              Load_Start;
    logic [ADDR_W:0]   Load_Len;
    logic              In_Valid;
    logic [31:0]       In_Data;
    logic              In_Ready;
    logic              Mem_WE;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [31:0]       Mem_WData;
    logic              CPU_Hold;
    logic [31:0]       PC_Value;
    logic              Busy;
    logic              Done;
    logic              Err;
    logic [31:0]       Checksum;

    ins_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .START_PC(START_PC)) dut (
        .CLK(CLK), .RST(RST), .Load_Start(Load_Start), .Load_Len(Load_Len),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .CPU_Hold(CPU_Hold), .PC_Value(PC_Value), .Busy(Busy), .Done(Done),
        .Err(Err), .Checksum(Checksum)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Observed activity, sampled mid-cycle.
    int          cyc = 0;
    int          hs_cyc_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    // Reference stimulus for the current load.
    logic [31:0] exp_words[$];
    int          busy_bad;

    always @(negedge CLK) begin
        if (In_Valid && In_Ready) hs_cyc_q.push_back(cyc);
        if (Mem_WE) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(Mem_Addr);
            wr_data_q.push_back(Mem_WData);
        end
        if (Done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        hs_cyc_q.delete();
        wr_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    function automatic logic [31:0] model_checksum();
        logic [31:0] s = 32'h0000_0000;
        foreach (exp_words[i]) s = s ^ exp_words[i];
        return s;
    endfunction

    // gap >= 0: fixed idle cycles between words; gap < 0: random 0..-gap.
    // ign_at >= 0: pulse Load_Start (length 5) once after that many words.
    // rst_at >= 0: return after that many words have been accepted.
    task automatic run_load(input int len, input int gap, input int ign_at, input int rst_at);
        int idx = 0;
        int guard = 0;
        int wait_n = 0;
        bit ign_done = 1'b0;
        bit accepted;
        clear_mon();
        busy_bad = 0;
        Load_Start = 1'b1;
        Load_Len = 9'(len);
        tick();
        Load_Start = 1'b0;
        while (idx < len && guard < 5000) begin
            if (rst_at >= 0 && idx == rst_at) break;
            if (ign_at >= 0 && idx == ign_at && !ign_done) begin
                Load_Start = 1'b1;
                Load_Len = 9'd5;
                ign_done = 1'b1;
            end else begin
                Load_Start = 1'b0;
            end
            if (wait_n > 0) begin
                In_Valid = 1'b0;
                In_Data = $urandom;
                wait_n--;
            end else begin
                In_Valid = 1'b1;
                In_Data = exp_words[idx];
            end
            if (Busy !== 1'b1) busy_bad++;
            accepted = In_Valid && In_Ready;
            tick();
            if (accepted) begin
                idx++;
                wait_n = (gap >= 0) ? gap : int'($urandom_range(-gap, 0));
            end
            guard++;
        end
        In_Valid = 1'b0;
        Load_Start = 1'b0;
        chk("load_bound", 32'(guard < 5000), 32'd1);
    endtask

    task automatic finish_and_check(input string tag);
        int g = 0;
        int len = exp_words.size();
        logic [31:0] sum_exp = model_checksum();
        while (Done !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        chk({tag, "_done_seen"}, 32'(Done), 32'd1);
        chk({tag, "_hold_in_done"}, 32'(CPU_Hold), 32'd1);
        chk({tag, "_busy_in_done"}, 32'(Busy), 32'd1);
        // Stray valid traffic in IDLE must not be written or folded in.
        In_Valid = 1'b1;
        In_Data = $urandom;
        tick();
        chk({tag, "_hold_after"}, 32'(CPU_Hold), 32'd0);
        chk({tag, "_busy_after"}, 32'(Busy), 32'd0);
        chk({tag, "_done_after"}, 32'(Done), 32'd0);
        chk({tag, "_pc"}, PC_Value, START_PC);
        chk({tag, "_ready_idle"}, 32'(In_Ready), 32'd0);
        tick();
        tick();
        In_Valid = 1'b0;
        chk({tag, "_hs_count"}, 32'(hs_cyc_q.size()), 32'(len));
        chk({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(len));
        for (int i = 0; i < len && i < wr_addr_q.size() && i < hs_cyc_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
            chk({tag, "_data"}, wr_data_q[i], exp_words[i]);
            chk({tag, "_lat"}, 32'(wr_cyc_q[i]), 32'(hs_cyc_q[i] + 1));
        end
        chk({tag, "_checksum"}, Checksum, sum_exp);
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        if (hs_cyc_q.size() == len && len > 0)
            chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(hs_cyc_q[len-1] + 2));
        chk({tag, "_err"}, 32'(Err), 32'd0);
        chk({tag, "_hold_idle"}, 32'(CPU_Hold), 32'd0);
    endtask

    initial begin
        logic [31:0] sum_prev;
        int rlen;
        RST = 1'b1;
        Load_Start = 1'b1;
        Load_Len = 9'd3;
        In_Valid = 1'b0;
        In_Data = 32'h0000_0000;
        tick();
        tick();
        RST = 1'b0;
        Load_Start = 1'b0;
        chk("rst_hold", 32'(CPU_Hold), 32'd1);
        chk("rst_ready", 32'(In_Ready), 32'd0);
        chk("rst_we", 32'(Mem_WE), 32'd0);
        chk("rst_addr", 32'(Mem_Addr), 32'd0);
        chk("rst_wdata", Mem_WData, 32'd0);
        chk("rst_pc", PC_Value, START_PC);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_sum", Checksum, 32'd0);
        tick();
        chk("rst_start_lost", 32'(Busy), 32'd0);

        // Basic back-to-back load.
        exp_words = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
        run_load(3, 0, -1, -1);
        finish_and_check("basic");

        // Gapped valid: four idle cycles between the two words.
        exp_words = '{$urandom, $urandom};
        run_load(2, 4, -1, -1);
        chk("gap_busy", 32'(busy_bad), 32'd0);
        finish_and_check("gap");

        // Full depth, data equals address.
        exp_words.delete();
        for (int i = 0; i < DEPTH; i++) exp_words.push_back(32'(i));
        run_load(DEPTH, 0, -1, -1);
        finish_and_check("full");

        // Illegal lengths leave the loader idle and the CPU released.
        clear_mon();
        sum_prev = Checksum;
        Load_Start = 1'b1;
        Load_Len = 9'd0;
        tick();
        Load_Start = 1'b0;
        chk("ill0_err", 32'(Err), 32'd1);
        chk("ill0_busy", 32'(Busy), 32'd0);
        chk("ill0_hold", 32'(CPU_Hold), 32'd0);
        tick();
        chk("ill0_ready", 32'(In_Ready), 32'd0);
        Load_Start = 1'b1;
        Load_Len = 9'd257;
        tick();
        Load_Start = 1'b0;
        In_Valid = 1'b1;
        In_Data = $urandom;
        tick();
        tick();
        In_Valid = 1'b0;
        chk("ill257_err", 32'(Err), 32'd1);
        chk("ill257_busy", 32'(Busy), 32'd0);
        chk("ill257_hold", 32'(CPU_Hold), 32'd0);
        chk("ill_sum", Checksum, sum_prev);
        chk("ill_writes", 32'(wr_addr_q.size()), 32'd0);

        // A legal load clears Err.
        exp_words = '{$urandom, $urandom, $urandom, $urandom};
        run_load(4, -2, -1, -1);
        finish_and_check("after_ill");

        // Load_Start during LOAD is ignored.
        exp_words = '{$urandom, $urandom, $urandom};
        run_load(3, 1, 1, -1);
        finish_and_check("ign_start");

        // Random lengths and gaps.
        for (int k = 0; k < 4; k++) begin
            rlen = int'($urandom_range(20, 1));
            exp_words.delete();
            for (int i = 0; i < rlen; i++) exp_words.push_back($urandom);
            run_load(rlen, -3, -1, -1);
            finish_and_check("rand");
        end

        // Reset after 5 of 10 words.
        exp_words.delete();
        for (int i = 0; i < 10; i++) exp_words.push_back($urandom);
        run_load(10, 0, -1, 5);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        clear_mon();
        chk("mid_busy", 32'(Busy), 32'd0);
        chk("mid_hold", 32'(CPU_Hold), 32'd1);
        chk("mid_sum", Checksum, 32'd0);
        chk("mid_done", 32'(Done), 32'd0);
        chk("mid_ready", 32'(In_Ready), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("mid_no_done", 32'(done_cnt), 32'd0);
        chk("mid_no_wr", 32'(wr_addr_q.size()), 32'd0);
        chk("mid_hold_kept", 32'(CPU_Hold), 32'd1);

        exp_words = '{$urandom, $urandom};
        run_load(2, 0, -1, -1);
        finish_and_check("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
